// File: rtl/sram_mem_stage.sv
// Pipeline memory stage: 32-bit loads/stores to a 16-bit asynchronous SRAM as two
// half-word accesses, each held for WAIT_CYCLES cycles while the pipeline is frozen.
module sram_mem_stage #(
    parameter int REGISTER_LEN  = 32,
    parameter int SRAM_ADDR_LEN = 18,
    parameter int SRAM_DATA_LEN = 16,
    parameter int BASE_ADDR     = 1024,
    parameter int WAIT_CYCLES   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_enable_in,
    input  logic                     mem_read_in,
    input  logic                     mem_write_in,
    input  logic [REGISTER_LEN-1:0]  alu_res_in,
    input  logic [REGISTER_LEN-1:0]  val_rm_in,
    output logic                     wb_enable_out,
    output logic                     mem_read_out,
    output logic [REGISTER_LEN-1:0]  alu_res_out,
    output logic [REGISTER_LEN-1:0]  mem_read_value,
    output logic                     ready,
    output logic [SRAM_ADDR_LEN-1:0] sram_addr,
    output logic [SRAM_DATA_LEN-1:0] sram_dq_out,
    output logic                     sram_dq_oe,
    input  logic [SRAM_DATA_LEN-1:0] sram_dq_in,
    output logic                     sram_we_n
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t                    state_reg;
    logic [CNT_W-1:0]          cnt_reg;
    logic [REGISTER_LEN-1:0]   mem_read_value_reg;

    logic                      req;
    logic                      is_write;
    logic                      is_read;
    logic                      cnt_last;
    logic                      in_access;
    logic [REGISTER_LEN-1:0]   offset;
    logic [SRAM_ADDR_LEN-2:0]  word;
    logic                      unused_bits;

    assign req      = mem_read_in | mem_write_in;
    // A simultaneous read+write is treated as a store only.
    assign is_write = mem_write_in;
    assign is_read  = mem_read_in & ~mem_write_in;
    assign cnt_last = (cnt_reg == CNT_W'(WAIT_CYCLES - 1));

    // Byte address relative to the SRAM window, in 32-bit words; wraps silently.
    assign offset      = alu_res_in - REGISTER_LEN'(BASE_ADDR);
    assign word        = offset[SRAM_ADDR_LEN:2];
    assign unused_bits = ^{offset[REGISTER_LEN-1:SRAM_ADDR_LEN+1], offset[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg          <= IDLE;
            cnt_reg            <= '0;
            mem_read_value_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        state_reg <= LOW;
                        cnt_reg   <= '0;
                    end
                end
                LOW: begin
                    if (cnt_last) begin
                        if (is_read)
                            mem_read_value_reg[SRAM_DATA_LEN-1:0] <= sram_dq_in;
                        cnt_reg   <= '0;
                        state_reg <= HIGH;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (cnt_last) begin
                        if (is_read)
                            mem_read_value_reg[2*SRAM_DATA_LEN-1:SRAM_DATA_LEN] <= sram_dq_in;
                        cnt_reg   <= '0;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                // Always return to IDLE so a request still held in DONE is not replayed.
                DONE: state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_access = (state_reg == LOW) || (state_reg == HIGH);

    always_comb begin
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        if (in_access) begin
            sram_addr = {word, (state_reg == HIGH)};
            if (is_write) begin
                sram_we_n   = 1'b0;
                sram_dq_oe  = 1'b1;
                sram_dq_out = (state_reg == HIGH) ? val_rm_in[2*SRAM_DATA_LEN-1 -: SRAM_DATA_LEN]
                                                  : val_rm_in[SRAM_DATA_LEN-1:0];
            end
        end
    end

    assign ready          = ((state_reg == IDLE) && !req) || (state_reg == DONE);
    assign mem_read_value = mem_read_value_reg;
    assign wb_enable_out  = wb_enable_in;
    assign mem_read_out   = mem_read_in;
    assign alu_res_out    = alu_res_in;

endmodule

// File: tb/tb_sram_mem_stage.sv
// Directed bench for sram_mem_stage: per-cycle expected bus traces are queued when an
// access is launched and popped on each falling edge, with a simple SRAM model attached.
module tb_sram_mem_stage;

    typedef logic [70:0] vec_t;

    logic        clk;
    logic        rst;
    logic        wb_enable_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic [31:0] alu_res_in;
    logic [31:0] val_rm_in;
    logic        wb_enable_out;
    logic        mem_read_out;
    logic [31:0] alu_res_out;
    logic [31:0] mem_read_value;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;

    logic [15:0] sram_model [0:255];
    vec_t        exp_q [$];
    int          check_cnt = 0;
    int          pass_cnt  = 0;
    int          fail_cnt  = 0;

    sram_mem_stage #(.WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .wb_enable_in(wb_enable_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .alu_res_in(alu_res_in), .val_rm_in(val_rm_in),
        .wb_enable_out(wb_enable_out), .mem_read_out(mem_read_out), .alu_res_out(alu_res_out),
        .mem_read_value(mem_read_value), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous SRAM: combinational read, write captured while we_n is low.
    assign sram_dq_in = sram_model[sram_addr[7:0]];
    always @(posedge clk) begin
        if (!sram_we_n) sram_model[sram_addr[7:0]] <= sram_dq_out;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t pack(logic rdy, logic we_n, logic oe, logic [17:0] a,
                                  logic [15:0] dq, logic [31:0] alu, logic mr, logic wb);
        return {rdy, we_n, oe, a, dq, alu, mr, wb};
    endfunction

    function automatic vec_t observe();
        return {ready, sram_we_n, sram_dq_oe, sram_addr, sram_dq_out, alu_res_out,
                mem_read_out, wb_enable_out};
    endfunction

    function automatic logic [17:0] half_addr(logic [31:0] byte_addr, logic hi);
        logic [31:0] w;
        w = (byte_addr - 32'd1024) >> 2;
        return {w[16:0], hi};
    endfunction

    task automatic chk(input string tag, input vec_t obs, input vec_t expv);
        check_cnt++;
        assert (obs === expv) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Called #1 after a rising edge; a full access returns #1 after the edge leaving DONE.
    task automatic run_op(input string tag, input logic wb, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rv, input int ncyc);
        logic        hi;
        logic [15:0] dq;
        wb_enable_in = wb; mem_read_in = rd; mem_write_in = wr;
        alu_res_in = a; val_rm_in = d;
        for (int k = 0; k < 6; k++) begin
            if (k == 0)
                exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 18'd0, 16'd0, a, rd, wb));
            else if (k == 5)
                exp_q.push_back(pack(1'b1, 1'b1, 1'b0, 18'd0, 16'd0, a, rd, wb));
            else begin
                hi = (k >= 3);
                dq = wr ? (hi ? d[31:16] : d[15:0]) : 16'd0;
                exp_q.push_back(pack(1'b0, ~wr, wr, half_addr(a, hi), dq, a, rd, wb));
            end
        end
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            chk($sformatf("%s cyc%0d", tag, k), observe(), exp_q.pop_front());
            if (k == 5)
                chk($sformatf("%s read_value", tag), vec_t'(mem_read_value), vec_t'(exp_rv));
            if (k < ncyc - 1 || ncyc == 6) begin
                @(posedge clk);
                #1;
            end
        end
        if (ncyc < 6) exp_q.delete();
        $display("op %s rd=%0b wr=%0b addr=%0d data=%h read_value=%h", tag, rd, wr, a, d,
                 mem_read_value);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) sram_model[i] = 16'h0000;
        rst = 1'b0;
        wb_enable_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
        alu_res_in = 32'd0; val_rm_in = 32'd0;

        @(negedge clk);
        chk("reset outputs", observe(), pack(1'b1, 1'b1, 1'b0, 18'd0, 16'd0, 32'd0, 1'b0, 1'b0));
        chk("reset read_value", vec_t'(mem_read_value), vec_t'(32'd0));
        @(posedge clk);
        #1 rst = 1'b1;
        $display("op reset released");

        wb_enable_in = 1'b1; alu_res_in = 32'h2A;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            exp_q.push_back(pack(1'b1, 1'b1, 1'b0, 18'd0, 16'd0, 32'h2A, 1'b0, 1'b1));
            chk($sformatf("nonmem cyc%0d", k), observe(), exp_q.pop_front());
            @(posedge clk);
            #1;
        end
        $display("op nonmem alu=2a");

        run_op("store1028", 1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 32'h0, 6);
        run_op("load1028",  1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 32'hDEADBEEF, 6);
        run_op("b2b_store1032", 1'b0, 1'b0, 1'b1, 32'd1032, 32'h0BADC0DE, 32'hDEADBEEF, 6);
        run_op("load1032",  1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 32'h0BADC0DE, 6);
        run_op("rdwr1040",  1'b1, 1'b1, 1'b1, 32'd1040, 32'hCAFEF00D, 32'h0BADC0DE, 6);
        run_op("load1040",  1'b1, 1'b1, 1'b0, 32'd1040, 32'h0, 32'hCAFEF00D, 6);
        run_op("store1020_wrap", 1'b0, 1'b0, 1'b1, 32'd1020, 32'h13579BDF, 32'hCAFEF00D, 6);
        run_op("load1020_wrap",  1'b1, 1'b1, 1'b0, 32'd1020, 32'h0, 32'h13579BDF, 6);

        // Abort a store in its first HIGH cycle, before the high half is written.
        run_op("abort1036", 1'b0, 1'b0, 1'b1, 32'd1036, 32'h12345678, 32'h0, 4);
        #2 rst = 1'b0;
        #1;
        chk("abort async outputs", observe(),
            pack(1'b0, 1'b1, 1'b0, 18'd0, 16'd0, 32'd1036, 1'b0, 1'b0));
        chk("abort read_value", vec_t'(mem_read_value), vec_t'(32'd0));
        mem_write_in = 1'b0;
        #1;
        chk("abort ready follows req", vec_t'(ready), vec_t'(1'b1));
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        run_op("load1036_half", 1'b1, 1'b1, 1'b0, 32'd1036, 32'h0, 32'h00005678, 6);
        run_op("load1028_again", 1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 32'hDEADBEEF, 6);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
